reg_bank_param: RTL and testbench
=================================

Name: reg_bank_param

Overview:
- Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, for the 8-bit CPU datapath. Generalises the single 4-bit load/hold register to multiple registers with one write port and two read ports.
- Adds in-place operations: load, increment, decrement, shift left/right and single-register clear, plus registered carry and zero flags.
- Bus drive is an enable flag plus a forced-zero value. There is no high-impedance output.

Parameters:
- WIDTH, 8, bits per register (at least 2).
- DEPTH, 4, number of registers (at least 2).
- AW, $clog2(DEPTH), select width (derived; do not override).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- CLR_n  in  1  reset, synchronous, active-low.
- OP  in  3  operation on register WSEL (encodings below).
- WSEL  in  AW  target register for OP.
- D  in  WIDTH  load data for OP_LOAD.
- SIN  in  1  serial-in bit for the shift ops.
- RSEL_A  in  AW  read select, port A.
- OE_A_n  in  1  port A output enable, active-low.
- Q_A  out  WIDTH  port A data; all zeros when disabled.
- DRV_A  out  1  high when port A is driving the bus.
- RSEL_B  in  AW  read select, port B; always enabled.
- Q_B  out  WIDTH  port B data.
- CARRY  out  1  registered carry/borrow/shift-out flag.
- ZERO  out  1  registered flag: result of last writing op was 0.

Behaviour:
- Reset: while CLR_n=0 at a rising CLK edge, all registers become 0, CARRY=0, ZERO=1. OP is ignored on that edge. Reset is honoured mid-sequence, overriding any OP.
- OP encodings (held in the package):
  - 000 NOP: hold all state.
  - 001 LOAD: reg <= D.
  - 010 INC: reg + 1.
  - 011 DEC: reg - 1.
  - 100 SHL: {reg[W-2:0], SIN}.
  - 101 SHR: {SIN, reg[W-1:1]}.
  - 110 CLR1: reg <= 0.
  - 111: reserved; behaves as NOP.
- Latency: a writing op takes effect at the next rising edge. CARRY and ZERO update on that same edge.
- Non-writing ops (NOP, reserved): CARRY and ZERO hold.
- Arithmetic is modulo 2^WIDTH:
  - INC of all-ones gives 0 with CARRY=1; any other INC gives CARRY=0.
  - DEC of 0 gives all-ones with CARRY=1 (borrow); any other DEC gives CARRY=0.
  - SHL: CARRY = old MSB. SHR: CARRY = old LSB.
  - LOAD and CLR1: CARRY=0.
- ZERO = (new register value == 0) for every writing op.
- Reads are combinational from stored state:
  - Q_A = OE_A_n ? 0 : reg[RSEL_A]; DRV_A = ~OE_A_n.
  - Q_B = reg[RSEL_B].
- Read during write of the same register returns the old value until the edge. There is no bypass.
- Both ports may select the same register, including the one being written.
- Only register WSEL changes on a writing op; all other registers hold.

Decomposition:
- Package reg_bank_pkg holds:
  - OP_* localparams (3-bit encodings).
  - an op-is-writing helper function.
- Sub-module reg_bank_op_unit: purely combinational, parametrised by WIDTH.
  - Inputs: old value, OP, D, SIN.
  - Outputs: new value, carry, write-enable.
- The top level holds the storage array, reset logic, flag registers and read multiplexers.

Test Plan (WIDTH=8, DEPTH=4):
- Reset, then read: CLR_n=0 for one edge, then RSEL_B=0..3 -> Q_B=0x00 each; CARRY=0, ZERO=1. OE_A_n=1 -> Q_A=0x00, DRV_A=0.
- Load and isolation: LOAD WSEL=2 D=0xA5 -> next edge reg2=0xA5, other registers 0. ZERO=0, CARRY=0. OE_A_n=0, RSEL_A=2 -> Q_A=0xA5, DRV_A=1.
- Wrap: LOAD r1=0xFF, then INC r1 -> r1=0x00, CARRY=1, ZERO=1. Then DEC r1 -> 0xFF, CARRY=1, ZERO=0. Then DEC r1 -> 0xFE, CARRY=0.
- Shifts: r3=0x81. SHL SIN=0 -> 0x02, CARRY=1. SHR SIN=1 -> 0x81, CARRY=0. SHR SIN=0 -> 0x40, CARRY=1.
- Read-during-write: r0=0x10, INC r0 with RSEL_A=RSEL_B=0. Before the edge Q_A=Q_B=0x10; after the edge both read 0x11. NOP and reserved 111 then leave r0, CARRY and ZERO unchanged.
- Reset mid-op: CLR_n=0 on the same edge as LOAD r1=0x55 -> r1=0x00, ZERO=1, CARRY=0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - operation encodings and helpers for the register bank
package reg_bank_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_CLR1 = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  // Everything except NOP and the reserved code updates a register and the flags.
  function automatic logic op_writes(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/reg_bank_op_unit.sv
// rtl/reg_bank_op_unit.sv - combinational next-value and carry for one register op
module reg_bank_op_unit
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] old_val,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] new_val,
  output logic             carry,
  output logic             we
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  // The extra top bit is the carry out of INC and the borrow out of DEC.
  assign sum_ext  = {1'b0, old_val} + (WIDTH+1)'(1);
  assign diff_ext = {1'b0, old_val} - (WIDTH+1)'(1);

  always_comb begin
    new_val = old_val;
    carry   = 1'b0;
    we      = op_writes(op);
    case (op)
      OP_LOAD: new_val = d;
      OP_INC: begin
        new_val = sum_ext[WIDTH-1:0];
        carry   = sum_ext[WIDTH];
      end
      OP_DEC: begin
        new_val = diff_ext[WIDTH-1:0];
        carry   = diff_ext[WIDTH];
      end
      OP_SHL: begin
        new_val = {old_val[WIDTH-2:0], sin};
        carry   = old_val[WIDTH-1];
      end
      OP_SHR: begin
        new_val = {sin, old_val[WIDTH-1:1]};
        carry   = old_val[0];
      end
      OP_CLR1: new_val = '0;
      default: new_val = old_val;
    endcase
  end

endmodule

// File: rtl/reg_bank_param.sv
// rtl/reg_bank_param.sv - register bank with one op/write port, two read ports and flags
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [2:0]       OP,
  input  logic [AW-1:0]    WSEL,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  input  logic [AW-1:0]    RSEL_A,
  input  logic             OE_A_n,
  output logic [WIDTH-1:0] Q_A,
  output logic             DRV_A,
  input  logic [AW-1:0]    RSEL_B,
  output logic [WIDTH-1:0] Q_B,
  output logic             CARRY,
  output logic             ZERO
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] new_val;
  logic             new_carry;
  logic             we;

  reg_bank_op_unit #(.WIDTH(WIDTH)) u_op (
    .old_val (regs[WSEL]),
    .op      (OP),
    .d       (D),
    .sin     (SIN),
    .new_val (new_val),
    .carry   (new_carry),
    .we      (we)
  );

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      CARRY <= 1'b0;
      ZERO  <= 1'b1;
    end else if (we) begin
      regs[WSEL] <= new_val;
      CARRY      <= new_carry;
      ZERO       <= (new_val == '0);
    end
  end

  // Reads come straight from storage; a same-cycle write is not forwarded.
  assign Q_A   = OE_A_n ? '0 : regs[RSEL_A];
  assign DRV_A = ~OE_A_n;
  assign Q_B   = regs[RSEL_B];

endmodule

// File: tb/tb_reg_bank_param.sv
// tb/tb_reg_bank_param.sv - vector table, corner sequences and random model check for reg_bank_param
module tb_reg_bank_param;

  logic       CLK = 1'b0;
  logic       CLR_n = 1'b1;
  logic [2:0] OP = 3'b000;
  logic [1:0] WSEL = '0;
  logic [7:0] D = '0;
  logic       SIN = 1'b0;
  logic [1:0] RSEL_A = '0;
  logic       OE_A_n = 1'b1;
  logic [7:0] Q_A;
  logic       DRV_A;
  logic [1:0] RSEL_B = '0;
  logic [7:0] Q_B;
  logic       CARRY;
  logic       ZERO;

  int n_vec = 0;
  int n_err = 0;

  reg_bank_param #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .OP(OP), .WSEL(WSEL), .D(D), .SIN(SIN),
    .RSEL_A(RSEL_A), .OE_A_n(OE_A_n), .Q_A(Q_A), .DRV_A(DRV_A),
    .RSEL_B(RSEL_B), .Q_B(Q_B), .CARRY(CARRY), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       clr_n;
    logic [2:0] op;
    logic [1:0] wsel;
    logic [7:0] d;
    logic       sin;
    logic [1:0] rsel_a;
    logic       oe_a_n;
    logic [1:0] rsel_b;
    logic [7:0] e_qa;
    logic [7:0] e_qb;
    logic       e_c;
    logic       e_z;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic clr_n, logic [2:0] op, logic [1:0] wsel, logic [7:0] d,
                              logic sin, logic [1:0] rsel_a, logic oe_a_n, logic [1:0] rsel_b,
                              logic [7:0] e_qa, logic [7:0] e_qb, logic e_c, logic e_z);
    vec_t v;
    v.clr_n = clr_n; v.op = op; v.wsel = wsel; v.d = d; v.sin = sin;
    v.rsel_a = rsel_a; v.oe_a_n = oe_a_n; v.rsel_b = rsel_b;
    v.e_qa = e_qa; v.e_qb = e_qb; v.e_c = e_c; v.e_z = e_z;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr_n, input logic [2:0] op, input logic [1:0] wsel,
                       input logic [7:0] d, input logic sin, input logic [1:0] rsel_a,
                       input logic oe_a_n, input logic [1:0] rsel_b);
    @(negedge CLK);
    CLR_n = clr_n; OP = op; WSEL = wsel; D = d; SIN = sin;
    RSEL_A = rsel_a; OE_A_n = oe_a_n; RSEL_B = rsel_b;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] qa, input logic [7:0] qb,
                         input logic c, input logic z, input logic drv);
    chk({tag, ".Q_A"}, int'(Q_A), int'(qa));
    chk({tag, ".Q_B"}, int'(Q_B), int'(qb));
    chk({tag, ".CARRY"}, int'(CARRY), int'(c));
    chk({tag, ".ZERO"}, int'(ZERO), int'(z));
    chk({tag, ".DRV_A"}, int'(DRV_A), int'(drv));
  endtask

  int m_reg[4];
  int m_c;
  int m_z;

  // Reference model: plain modulo-256 arithmetic on integers.
  task automatic model_step(input logic clr_n, input int op, input int w, input int d, input int s);
    int o;
    int nv;
    int c;
    o = m_reg[w];
    nv = o;
    c = 0;
    if (!clr_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 0;
      m_c = 0; m_z = 1;
    end else if (op >= 1 && op <= 6) begin
      case (op)
        1: nv = d;
        2: begin nv = (o + 1) % 256;   c = (o == 255) ? 1 : 0; end
        3: begin nv = (o + 255) % 256; c = (o == 0) ? 1 : 0;   end
        4: begin nv = (o * 2) % 256 + s; c = o / 128; end
        5: begin nv = o / 2 + s * 128;   c = o % 2;   end
        default: nv = 0;
      endcase
      m_reg[w] = nv;
      m_c = c;
      m_z = (nv == 0) ? 1 : 0;
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 3'b001, 1, 8'h77, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1);
    tbl[1]  = mk(1, 3'b000, 0, 8'h00, 0, 0, 1, 1, 8'h00, 8'h00, 0, 1);
    tbl[2]  = mk(1, 3'b000, 0, 8'h00, 0, 0, 1, 2, 8'h00, 8'h00, 0, 1);
    tbl[3]  = mk(1, 3'b000, 0, 8'h00, 0, 0, 1, 3, 8'h00, 8'h00, 0, 1);
    tbl[4]  = mk(1, 3'b001, 2, 8'hA5, 0, 2, 0, 2, 8'hA5, 8'hA5, 0, 0);
    tbl[5]  = mk(1, 3'b000, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    tbl[6]  = mk(1, 3'b000, 0, 8'h00, 0, 2, 1, 3, 8'h00, 8'h00, 0, 0);
    tbl[7]  = mk(1, 3'b001, 1, 8'hFF, 0, 1, 0, 1, 8'hFF, 8'hFF, 0, 0);
    tbl[8]  = mk(1, 3'b010, 1, 8'h00, 0, 1, 0, 1, 8'h00, 8'h00, 1, 1);
    tbl[9]  = mk(1, 3'b011, 1, 8'h00, 0, 1, 0, 1, 8'hFF, 8'hFF, 1, 0);
    tbl[10] = mk(1, 3'b011, 1, 8'h00, 0, 1, 0, 1, 8'hFE, 8'hFE, 0, 0);
    tbl[11] = mk(1, 3'b001, 3, 8'h81, 0, 3, 0, 3, 8'h81, 8'h81, 0, 0);
    tbl[12] = mk(1, 3'b100, 3, 8'h00, 0, 3, 0, 3, 8'h02, 8'h02, 1, 0);
    tbl[13] = mk(1, 3'b101, 3, 8'h00, 1, 3, 0, 3, 8'h81, 8'h81, 0, 0);
    tbl[14] = mk(1, 3'b101, 3, 8'h00, 0, 3, 0, 3, 8'h40, 8'h40, 1, 0);
    tbl[15] = mk(1, 3'b111, 3, 8'h00, 0, 3, 0, 3, 8'h40, 8'h40, 1, 0);
    tbl[16] = mk(1, 3'b110, 3, 8'hFF, 0, 3, 0, 3, 8'h00, 8'h00, 0, 1);
    tbl[17] = mk(1, 3'b000, 0, 8'h00, 0, 1, 0, 2, 8'hFE, 8'hA5, 0, 1);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].clr_n, tbl[i].op, tbl[i].wsel, tbl[i].d, tbl[i].sin,
            tbl[i].rsel_a, tbl[i].oe_a_n, tbl[i].rsel_b);
      @(posedge CLK); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_qa, tbl[i].e_qb, tbl[i].e_c, tbl[i].e_z,
              ~tbl[i].oe_a_n);
    end

    // Read during write: old value visible until the edge, then both ports see the result.
    drive(1, 3'b001, 0, 8'h10, 0, 0, 0, 0);
    drive(1, 3'b010, 0, 8'h00, 0, 0, 0, 0);
    #1;
    chk("rdw.pre.Q_A", int'(Q_A), 'h10);
    chk("rdw.pre.Q_B", int'(Q_B), 'h10);
    @(posedge CLK); #1;
    chk_all("rdw.post", 8'h11, 8'h11, 0, 0, 1);
    drive(1, 3'b000, 0, 8'hEE, 1, 0, 0, 0);
    @(posedge CLK); #1;
    chk_all("rdw.nop", 8'h11, 8'h11, 0, 0, 1);
    drive(1, 3'b111, 0, 8'hEE, 1, 0, 0, 0);
    @(posedge CLK); #1;
    chk_all("rdw.rsvd", 8'h11, 8'h11, 0, 0, 1);

    // Reset on the same edge as a LOAD overrides it.
    drive(1, 3'b001, 1, 8'h03, 0, 1, 0, 1);
    drive(1, 3'b101, 1, 8'h00, 0, 1, 0, 1);
    @(posedge CLK); #1;
    chk_all("rst.pre", 8'h01, 8'h01, 1, 0, 1);
    drive(0, 3'b001, 1, 8'h55, 0, 1, 0, 0);
    @(posedge CLK); #1;
    chk_all("rst.mid", 8'h00, 8'h00, 0, 1, 1);

    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_c = 0; m_z = 1;
    for (int n = 0; n < 400; n++) begin
      logic       r_clr;
      logic [2:0] r_op;
      logic [1:0] r_w, r_a, r_b;
      logic [7:0] r_d;
      logic       r_s, r_oe;
      int         e_qa;
      r_clr = ($urandom_range(0, 31) != 0);
      r_op  = 3'($urandom_range(0, 7));
      r_w   = 2'($urandom_range(0, 3));
      r_d   = 8'($urandom_range(0, 255));
      r_s   = 1'($urandom_range(0, 1));
      r_a   = 2'($urandom_range(0, 3));
      r_oe  = 1'($urandom_range(0, 1));
      r_b   = 2'($urandom_range(0, 3));
      if (n < 4) r_op = 3'b010;
      drive(r_clr, r_op, r_w, r_d, r_s, r_a, r_oe, r_b);
      #1;
      chk($sformatf("rnd%0d.pre.Q_B", n), int'(Q_B), m_reg[r_b]);
      model_step(r_clr, int'(r_op), int'(r_w), int'(r_d), int'(r_s));
      @(posedge CLK); #1;
      e_qa = r_oe ? 0 : m_reg[r_a];
      chk($sformatf("rnd%0d.Q_A", n), int'(Q_A), e_qa);
      chk($sformatf("rnd%0d.Q_B", n), int'(Q_B), m_reg[r_b]);
      chk($sformatf("rnd%0d.CARRY", n), int'(CARRY), m_c);
      chk($sformatf("rnd%0d.ZERO", n), int'(ZERO), m_z);
      chk($sformatf("rnd%0d.DRV_A", n), int'(DRV_A), r_oe ? 0 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
